parity_frame_ctrl: RTL
======================

Name: parity_frame_ctrl

Overview:
Sequencing controller for the team's serial parity generator datapath. Accepts parallel words over a valid/ready handshake and shifts each word out LSB-first, one bit per clock. Tracks running parity in a serial parity-tracker sub-module and appends one parity bit per frame. Sits between a word-oriented producer and a bit-serial consumer that can stall the stream via ser_ready.

Parameters:
DATA_W, 8, data bits per frame (2..32).
ODD_PARITY, 0, 0 = even parity bit (XOR of data bits); 1 = odd parity bit (inverted XOR).
CNT_W, 8, width of frame_cnt.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  controller can take a word this cycle.
in_data  input  DATA_W  word to serialise; sampled only on accept.
ser_out  output  1  serial bit (data LSB-first, then the parity bit).
ser_valid  output  1  ser_out is meaningful.
ser_last  output  1  current bit is the parity bit.
ser_ready  input  1  consumer takes the bit this cycle.
busy  output  1  frame in progress (state != IDLE).
frame_cnt  output  CNT_W  frames completed, modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- States: IDLE, SHIFT, PARITY. Encodings are defined in the shared package.
- Reset (async, immediate):
  - state=IDLE, shift reg=0, bit_idx=0, parity tracker=0, frame_cnt=0.
  - Outputs: ser_valid=0, ser_last=0, ser_out=0, busy=0, in_ready=1.
- Outputs are Moore/combinational from registers:
  - in_ready = (IDLE) | (PARITY & ser_ready).
  - ser_valid = SHIFT | PARITY; ser_last = PARITY; busy = !IDLE.
  - ser_out = shreg[0] in SHIFT; (par ^ ODD_PARITY) in PARITY; 0 in IDLE.
- Accept: in_valid & in_ready at an edge.
  - Load shreg<=in_data, bit_idx<=0, par<=0, state<=SHIFT.
- SHIFT, transfer (ser_ready=1):
  - par<=par^shreg[0], shreg>>=1, bit_idx++.
  - When bit_idx==DATA_W-1: state<=PARITY.
- PARITY, transfer:
  - frame_cnt++ (wraps 2^CNT_W-1 -> 0).
  - If in_valid in the same cycle: accept the next word and go directly to SHIFT (gapless streaming).
  - Otherwise go to IDLE.
- Stall: ser_ready=0 in SHIFT/PARITY holds all state. ser_out, ser_valid and ser_last stay stable.
- Latency: word accepted at edge k gives data bit 0 valid in cycle k+1 and the parity bit in cycle k+1+DATA_W (no stalls). Frame period is DATA_W+1 cycles back-to-back.
- in_data is ignored except on accept.
- in_valid in IDLE with ser_ready=0 is still accepted; the stall only affects the serial side.
- Reset mid-frame: the partial frame is discarded, no parity bit is emitted, frame_cnt=0.
- bit_idx width is clog2(DATA_W).

Decomposition:
- Package parity_ctrl_pkg:
  - state localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_PARITY=2'd2.
  - clog2 helper function.
- Sub-module serial_par_track: the serial parity datapath.
  - Inputs: clk, rst, clr, en, bit_in, odd.
  - Output: par_out.
  - Par register toggles on en & bit_in and is cleared by clr.
- The controller drives clr on accept and en on SHIFT transfers.

Test Plan:
- DATA_W=8, even: send 8'hA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 then parity 0 with ser_last=1; frame_cnt 0->1.
- Even parity, 8'h07 -> bits 1,1,1,0,0,0,0,0, parity 1. With ODD_PARITY=1, 8'h00 -> eight 0s, parity 1.
- Back-to-back: in_valid held high with 8'hFF then 8'h01 -> 18 consecutive ser_valid cycles, no IDLE gap.
  - Parities 0 and 1; in_ready high only in IDLE and the parity-bit cycles.
- Stall: ser_ready=0 for 3 cycles while bit 3 of 8'h08 is presented -> ser_out stays 1 and shreg/bit_idx are frozen. The frame resumes with parity 1.
- Reset: assert rst asynchronously between edges during bit 4 -> outputs go to reset values without waiting for a clock edge, no ser_last seen. The next word frames correctly.
- Wrap: 256 consecutive frames -> frame_cnt returns to 0.

Source files
------------

// File: rtl/parity_ctrl_pkg.sv
// rtl/parity_ctrl_pkg.sv - shared state encodings and helpers for the parity frame controller
// Contents:
//   S_IDLE, S_SHIFT, S_PARITY : controller state encodings
//   state_t                   : state register type
//   clog2()                   : ceiling log2 used to size the bit index
package parity_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SHIFT  = 2'd1;
  localparam state_t S_PARITY = 2'd2;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_par_track.sv
// rtl/serial_par_track.sv - serial running-parity tracker
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the running parity (new frame)
//   en       : a data bit is being transferred this cycle
//   bit_in   : the data bit being transferred
//   odd      : 1 selects odd parity (inverted XOR) on par_out
//   par_out  : parity bit for the bits accumulated so far
module serial_par_track (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  input  logic odd,
  output logic par_out
);

  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (clr) begin
      par_q <= 1'b0;
    end else if (en && bit_in) begin
      par_q <= ~par_q;
    end
  end

  assign par_out = par_q ^ odd;

endmodule

// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - word-to-serial framer appending one parity bit per frame
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : word handshake from the producer
//   in_data             : word to serialise, sampled on accept
//   ser_out             : serial bit, data LSB-first then parity
//   ser_valid/ser_ready : bit handshake to the consumer
//   ser_last            : current bit is the parity bit
//   busy                : a frame is in progress
//   frame_cnt           : frames completed, wrapping
module parity_frame_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  input  logic              ser_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = clog2(DATA_W);

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic               par_bit;
  logic               accept;
  logic               shift_xfer;

  assign accept     = in_valid && in_ready;
  assign shift_xfer = (state == S_SHIFT) && ser_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            bit_idx <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(DATA_W - 1)) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (ser_ready) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            // A waiting word is taken in the parity cycle so frames stream gaplessly.
            if (in_valid) begin
              shreg   <= in_data;
              bit_idx <= '0;
              state   <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Running parity is cleared on every accept and accumulates only transferred data bits.
  serial_par_track u_par (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (shift_xfer),
    .bit_in  (shreg[0]),
    .odd     (ODD_PARITY != 0),
    .par_out (par_bit)
  );

  assign in_ready  = (state == S_IDLE) || ((state == S_PARITY) && ser_ready);
  assign ser_valid = (state == S_SHIFT) || (state == S_PARITY);
  assign ser_last  = (state == S_PARITY);
  assign busy      = (state != S_IDLE);

  always_comb begin
    ser_out = 1'b0;
    case (state)
      S_SHIFT:  ser_out = shreg[0];
      S_PARITY: ser_out = par_bit;
      default:  ser_out = 1'b0;
    endcase
  end

endmodule
